// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : Multi-channel push-button conditioner. Each channel has a 2-flop
//            synchronizer, a stable-level debouncer, registered press/release
//            pulses and a hold tracker that emits a long-press pulse and,
//            optionally, auto-repeat pulses while the button stays down.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk         in   1     rising-edge clock for all state
//   Rst_n       in   1     asynchronous active-low reset (synchronized upstream)
//   btn_in      in   NCH   raw asynchronous button levels
//   btn_out     out  NCH   debounced level per channel
//   press       out  NCH   1-cycle pulse after an accepted 0->1 change
//   release_o   out  NCH   1-cycle pulse after an accepted 1->0 change
//                          (`release` is a SystemVerilog keyword)
//   long_press  out  NCH   1-cycle pulse on long press and on each repeat
// ============================================================================
module debounce_multi #(
  parameter int NCH        = 4,
  parameter int STABLE_CNT = 1048576,
  parameter int LONG_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000,
  parameter int REPEAT_EN  = 0
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [NCH-1:0] btn_in,
  output logic [NCH-1:0] btn_out,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] release_o,
  output logic [NCH-1:0] long_press
);

  localparam int SW       = $clog2(STABLE_CNT) + 1;
  localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int HW       = $clog2(HOLD_MAX) + 1;

  localparam logic [SW-1:0] STABLE_TC = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] LONG_TC   = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] REPEAT_TC = HW'(REPEAT_CNT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    state_q, state_d;
    logic          press_q, rel_q, lp_q, lp_d;
    logic          flip, rise, fall;

    // The debounced level inverts on the edge where the synchronized input
    // has disagreed with it for STABLE_CNT consecutive edges.
    assign flip = (s2_q != lvl_q) && (stab_q == STABLE_TC);
    assign rise = flip & ~lvl_q;
    assign fall = flip &  lvl_q;

    always_comb begin
      stab_d = stab_q;
      lvl_d  = lvl_q;
      if (s2_q == lvl_q) begin
        stab_d = '0;
      end else if (stab_q == STABLE_TC) begin
        stab_d = '0;
        lvl_d  = ~lvl_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end

    // Hold FSM: state register
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Hold FSM: next state. Transitions key off the same edge that produces
    // the press/release pulses so the FSM and the level never disagree.
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE: begin
          if (rise) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (fall)                      state_d = ST_IDLE;
          else if (hold_q == LONG_TC)    state_d = ST_REPEAT;
        end
        ST_REPEAT: begin
          if (fall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Hold FSM: outputs (long-press request and hold counter update).
    // A release on the terminal-count edge suppresses the pulse.
    always_comb begin
      lp_d   = 1'b0;
      hold_d = hold_q;
      if (!lvl_q || fall) begin
        hold_d = '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (hold_q == LONG_TC) begin
              lp_d   = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (REPEAT_EN != 0) begin
              if (hold_q == REPEAT_TC) begin
                lp_d   = 1'b1;
                hold_d = '0;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end else if (hold_q != REPEAT_TC) begin
              // Without auto-repeat the counter parks at its terminal value.
              hold_d = hold_q + 1'b1;
            end
          end
          default: hold_d = '0;
        endcase
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        lvl_q   <= 1'b0;
        stab_q  <= '0;
        hold_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        s1_q    <= btn_in[g];
        s2_q    <= s1_q;
        lvl_q   <= lvl_d;
        stab_q  <= stab_d;
        hold_q  <= hold_d;
        press_q <= rise;
        rel_q   <= fall;
        lp_q    <= lp_d;
      end
    end

    assign btn_out[g]    = lvl_q;
    assign press[g]      = press_q;
    assign release_o[g]  = rel_q;
    assign long_press[g] = lp_q;
  end

endmodule
`default_nettype wire
